// File: rtl/act_stream_ctrl.sv
// act_stream_ctrl: sequences one burst of input-buffer elements through a shared activation unit
// and writes each result to the output buffer, sustaining one element per cycle.
module act_stream_ctrl #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 10,
  parameter int LEN_W       = 11,
  parameter int ACT_LATENCY = 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic [1:0]        cfg_func,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              act_en,
  output logic [1:0]        act_sel,
  output logic [WIDTH-1:0]  act_data,
  input  logic [WIDTH-1:0]  act_out,
  input  logic              act_rdy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   written;
  logic [ADDR_W-1:0]  src_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [1:0]         func_q;
  logic [ACT_LATENCY:0] vld;
  logic               err_q;
  logic               issue;
  logic               due;

  // Issue is decided in the same cycle from registered state so pause gates reads with no extra lag.
  assign issue = (state == ISSUE) && !pause && (issued != len_q);
  assign due   = vld[ACT_LATENCY];

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state   <= IDLE;
      len_q   <= '0;
      issued  <= '0;
      written <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      func_q  <= '0;
      vld     <= '0;
      err_q   <= 1'b0;
    end else begin
      vld <= {vld[ACT_LATENCY-1:0], issue};
      if (issue) issued <= issued + LEN_W'(1);
      // A missing act_rdy is flagged, but the slot is still written so the count stays aligned.
      if (due) begin
        written <= written + LEN_W'(1);
        if (!act_rdy) err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_start) begin
            len_q   <= cfg_len;
            src_q   <= cfg_src_base;
            dst_q   <= cfg_dst_base;
            func_q  <= cfg_func;
            issued  <= '0;
            written <= '0;
            err_q   <= 1'b0;
            state   <= (cfg_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if ((issue && (issued + LEN_W'(1) == len_q)) || (issued == len_q)) state <= DRAIN;
        end
        DRAIN: begin
          if ((due && (written + LEN_W'(1) == len_q)) || (written == len_q)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE) || cfg_start;
  assign done     = (state == DONE);
  assign err      = err_q;
  assign rd_en    = issue;
  assign rd_addr  = issue ? (src_q + issued[ADDR_W-1:0]) : '0;
  assign act_en   = vld[0];
  assign act_sel  = func_q;
  assign act_data = vld[0] ? rd_data : '0;
  assign wr_en    = due;
  assign wr_addr  = due ? (dst_q + written[ADDR_W-1:0]) : '0;
  assign wr_data  = due ? act_out : '0;

endmodule

// File: tb/tb_act_stream_ctrl.sv
// tb_act_stream_ctrl: drives bursts from a table against buffer and activation-unit models,
// checking reads and writes through scoreboard queues plus done timing, busy and err.
module tb_act_stream_ctrl;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        cfg_start = 1'b0;
  logic [10:0] cfg_len = '0;
  logic [9:0]  cfg_src_base = '0;
  logic [9:0]  cfg_dst_base = '0;
  logic [1:0]  cfg_func = '0;
  logic        pause = 1'b0;
  logic        busy, done, err, rd_en, act_en, wr_en;
  logic [9:0]  rd_addr, wr_addr;
  logic [7:0]  rd_data, act_data, act_out, wr_data;
  logic [1:0]  act_sel;
  logic        act_rdy;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int act_seen = 0;
  int drop_idx = -1;
  logic [1:0] exp_sel = '0;

  typedef struct { logic [9:0] addr; logic [7:0] data; } wr_t;
  logic [9:0] rd_q[$];
  wr_t        wr_q[$];

  typedef struct {
    int src; int dst; int len; int func;
    int pause_after; int pause_cycles; int restart_at; int drop;
    int exp_done; int exp_err;
  } rec_t;

  act_stream_ctrl dut (
    .iClk(iClk), .iRst(iRst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_func(cfg_func),
    .pause(pause), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .act_en(act_en), .act_sel(act_sel), .act_data(act_data),
    .act_out(act_out), .act_rdy(act_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 iClk = ~iClk;

  function automatic logic [7:0] mem_val(input logic [9:0] a);
    logic [9:0] t;
    t = a - 10'd2;
    return t[7:0];
  endfunction

  function automatic logic [7:0] act_model(input logic [1:0] sel, input logic [7:0] x);
    logic signed [7:0] s;
    s = x;
    case (sel)
      2'd0: return (s < 0) ? 8'd0 : x;
      2'd1: return (s < 0) ? 8'(s >>> 2) : x;
      2'd2: return (s > 8'sd64) ? 8'd64 : ((s < -8'sd64) ? 8'hC0 : x);
      default: return 8'(8'sd64 + (s >>> 2));
    endcase
  endfunction

  // Input buffer: one-cycle read latency.
  always @(posedge iClk or negedge iRst) begin
    if (!iRst) rd_data <= '0;
    else       rd_data <= rd_en ? mem_val(rd_addr) : 8'h00;
  end

  // Activation unit with one-cycle latency; act_rdy withheld for element drop_idx.
  always @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      act_out <= '0;
      act_rdy <= 1'b0;
    end else begin
      act_out <= act_en ? act_model(act_sel, act_data) : 8'h00;
      act_rdy <= act_en && (act_seen != drop_idx + 1);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge iClk) begin
    if (iRst) begin
      if (act_en) begin
        act_seen++;
        checkOutput("act_sel", act_sel, exp_sel);
      end
      if (rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) checkOutput("unexpected_rd", rd_addr, -1);
        else checkOutput("rd_addr", rd_addr, rd_q.pop_front());
      end
      if (wr_en) begin
        if (wr_q.size() == 0) checkOutput("unexpected_wr", wr_addr, -1);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          checkOutput("wr_addr", wr_addr, e.addr);
          checkOutput("wr_data", wr_data, e.data);
        end
      end
    end
  end

  // Runs one burst from posedge+1; returns at posedge+1 of the cycle after done.
  task automatic applyStimulus(input rec_t r);
    int cyc;
    int paused;
    int done_cyc;
    logic [9:0] a;
    paused = 0;
    done_cyc = -1;
    rd_cnt = 0;
    act_seen = 0;
    drop_idx = r.drop;
    exp_sel = 2'(r.func);
    for (int i = 0; i < r.len; i++) begin
      a = 10'(r.src + i);
      rd_q.push_back(a);
      wr_q.push_back('{addr: 10'(r.dst + i), data: act_model(2'(r.func), mem_val(a))});
    end
    cfg_len = 11'(r.len);
    cfg_src_base = 10'(r.src);
    cfg_dst_base = 10'(r.dst);
    cfg_func = 2'(r.func);
    cfg_start = 1'b1;
    @(negedge iClk);
    checkOutput("busy_at_start", busy, 1);
    @(posedge iClk);
    #1;
    cfg_start = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == 1) checkOutput("err_cleared", err, 0);
      pause = (r.pause_cycles > 0) && (rd_cnt == r.pause_after) && (paused < r.pause_cycles);
      if (pause) paused++;
      if (cyc == r.restart_at) begin
        cfg_start = 1'b1; cfg_func = 2'd3; cfg_len = 11'd2; cfg_src_base = 10'd500;
      end else cfg_start = 1'b0;
      @(negedge iClk);
      checkOutput("busy_in_burst", busy, 1);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge iClk);
      #1;
    end
    pause = 1'b0;
    cfg_start = 1'b0;
    checkOutput("done_cycle", done_cyc, r.exp_done);
    checkOutput("err_at_done", err, r.exp_err);
    @(posedge iClk);
    #1;
    checkOutput("done_busy_after", {done, busy}, 0);
    checkOutput("err_sticky", err, r.exp_err);
    checkOutput("rd_q_left", rd_q.size(), 0);
    checkOutput("wr_q_left", wr_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
  endtask

  rec_t tbl[7];

  initial begin
    rec_t r;
    tbl[0] = '{src: 0,    dst: 100,  len: 4, func: 0, pause_after: 0, pause_cycles: 0, restart_at: 0, drop: -1, exp_done: 7,  exp_err: 0};
    tbl[1] = '{src: 5,    dst: 5,    len: 0, func: 0, pause_after: 0, pause_cycles: 0, restart_at: 0, drop: -1, exp_done: 1,  exp_err: 0};
    tbl[2] = '{src: 0,    dst: 200,  len: 8, func: 2, pause_after: 2, pause_cycles: 3, restart_at: 0, drop: -1, exp_done: 14, exp_err: 0};
    tbl[3] = '{src: 10,   dst: 300,  len: 6, func: 1, pause_after: 0, pause_cycles: 0, restart_at: 3, drop: -1, exp_done: 9,  exp_err: 0};
    tbl[4] = '{src: 1022, dst: 1021, len: 4, func: 3, pause_after: 0, pause_cycles: 0, restart_at: 0, drop: -1, exp_done: 7,  exp_err: 0};
    tbl[5] = '{src: 40,   dst: 0,    len: 5, func: 0, pause_after: 0, pause_cycles: 0, restart_at: 0, drop: 2,  exp_done: 8,  exp_err: 1};
    tbl[6] = '{src: 7,    dst: 7,    len: 1, func: 1, pause_after: 0, pause_cycles: 0, restart_at: 0, drop: -1, exp_done: 4,  exp_err: 0};

    #1;
    checkOutput("reset_outputs",
                {busy, done, err, rd_en, act_en, wr_en, rd_addr, wr_addr, wr_data, act_data, act_sel}, 0);
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(posedge iClk);
    #1;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] burst %0d: src=%0d dst=%0d len=%0d func=%0d", i, tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].func);
      applyStimulus(tbl[i]);
    end

    // Reset in the middle of a burst: strobes drop at once, no done, then a fresh burst runs.
    cfg_len = 11'd8; cfg_src_base = 10'd60; cfg_dst_base = 10'd600; cfg_func = 2'd2;
    exp_sel = 2'd2;
    drop_idx = -1;
    for (int i = 0; i < 8; i++) begin
      rd_q.push_back(10'(60 + i));
      wr_q.push_back('{addr: 10'(600 + i), data: act_model(2'd2, mem_val(10'(60 + i)))});
    end
    cfg_start = 1'b1;
    @(posedge iClk);
    #1;
    cfg_start = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    checkOutput("mid_burst_active", {rd_en, act_en, wr_en, busy}, 4'b1111);
    iRst = 1'b0;
    #1;
    checkOutput("reset_mid_burst",
                {busy, done, err, rd_en, act_en, wr_en, rd_addr, wr_addr, wr_data, act_data, act_sel}, 0);
    rd_q.delete();
    wr_q.delete();
    @(negedge iClk);
    checkOutput("no_done_in_reset", {done, busy}, 0);
    @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    checkOutput("idle_after_reset", {done, busy, rd_en}, 0);
    r = tbl[0];
    r.func = 3;
    r.src = 20;
    applyStimulus(r);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
